fft_bfly_stage: RTL and testbench

- Parametrised radix-2 DIF butterfly stage for the streaming multi-lane FFT datapath. Processes NUM complex samples per beat and pairs sample n with sample n+DIST inside each N-point frame.
- Emits sums (a+b) and differences (a−b) in natural stage order.
- Buffers first-half beats internally when DIST ≥ NUM. Works in-beat when DIST < NUM.
- Twiddle multiplication is out of scope and handled by the downstream stage.

---
 rtl/fft_bfly_stage_if.sv | 34 +++
 rtl/fft_bfly_stage.sv | 186 ++++++++++++++++++
 tb/tb_fft_bfly_stage.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bfly_stage_if.sv
// fft_bfly_stage_if: streaming beat interface for the radix-2 DIF butterfly
// stage. Carries the input beat, the output beat and the busy flag.
// Macro FFT_BFLY_SCALE_EN narrows the result width to IN_WIDTH.
interface fft_bfly_stage_if #(
   parameter int IN_WIDTH = 9,
   parameter int NUM      = 16
);
`ifdef FFT_BFLY_SCALE_EN
   localparam int OUT_WIDTH = IN_WIDTH;
`else
   localparam int OUT_WIDTH = IN_WIDTH + 1;
`endif

   logic                      valid_in;
   logic [IN_WIDTH*NUM-1:0]   din_i;
   logic [IN_WIDTH*NUM-1:0]   din_q;
   logic                      valid_out;
   logic                      sop_out;
   logic [OUT_WIDTH*NUM-1:0]  dout_i;
   logic [OUT_WIDTH*NUM-1:0]  dout_q;
   logic                      busy;

   // Source / sink side of the stream
   modport master (
      output valid_in, din_i, din_q,
      input  valid_out, sop_out, dout_i, dout_q, busy
   );

   // Butterfly stage side
   modport slave (
      input  valid_in, din_i, din_q,
      output valid_out, sop_out, dout_i, dout_q, busy
   );
endinterface

// File: rtl/fft_bfly_stage.sv
// fft_bfly_stage: radix-2 DIF butterfly stage for a NUM-lane streaming FFT.
// DIST < NUM : lanes paired inside one beat, one output beat per input beat.
// DIST >= NUM: first-half beats buffered, sums emitted on the second half,
//              differences queued and drained on cycles without a sum.
// Macro FFT_BFLY_SCALE_EN: results become (x+1)>>>1, OUT_WIDTH = IN_WIDTH.
module fft_bfly_stage #(
   parameter int IN_WIDTH = 9,
   parameter int NUM      = 16,
   parameter int N        = 512,
   parameter int DIST     = 256
) (
   input  logic            clk,
   input  logic            rst,
   fft_bfly_stage_if.slave bus
);
`ifdef FFT_BFLY_SCALE_EN
   localparam int OUT_WIDTH = IN_WIDTH;
   localparam int XW        = IN_WIDTH + 2;
`else
   localparam int OUT_WIDTH = IN_WIDTH + 1;
   localparam int XW        = IN_WIDTH + 1;
`endif
   localparam int FB = N / NUM;
   localparam int FW = (FB > 1) ? $clog2(FB) : 1;
   localparam int LW = OUT_WIDTH * NUM;

   // Exact sum/difference of two sign-extended components, optionally halved
   function automatic logic [OUT_WIDTH-1:0] bf(input logic [IN_WIDTH-1:0] a,
                                               input logic [IN_WIDTH-1:0] b,
                                               input logic sub);
      logic signed [XW-1:0] ax, bx, x;
      ax = {{(XW-IN_WIDTH){a[IN_WIDTH-1]}}, a};
      bx = {{(XW-IN_WIDTH){b[IN_WIDTH-1]}}, b};
      x  = sub ? (ax - bx) : (ax + bx);
`ifdef FFT_BFLY_SCALE_EN
      x  = (x + XW'(1)) >>> 1;
`endif
      return OUT_WIDTH'(x);
   endfunction

   logic          valid_d, valid_q, sop_d, sop_q, pend;
   logic [LW-1:0] dout_i_d, dout_i_q, dout_q_d, dout_q_q;
   logic [FW-1:0] frm_cnt_d, frm_cnt_q;

   // Frame beat counter over valid input beats
   always_comb begin
      frm_cnt_d = frm_cnt_q;
      if (bus.valid_in)
         frm_cnt_d = (frm_cnt_q == FW'(FB - 1)) ? '0 : frm_cnt_q + FW'(1);
   end

   // Output and frame registers
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         sop_q     <= 1'b0;
         dout_i_q  <= '0;
         dout_q_q  <= '0;
         frm_cnt_q <= '0;
      end else begin
         valid_q   <= valid_d;
         sop_q     <= sop_d;
         dout_i_q  <= dout_i_d;
         dout_q_q  <= dout_q_d;
         frm_cnt_q <= frm_cnt_d;
      end
   end

   assign bus.valid_out = valid_q;
   assign bus.sop_out   = sop_q;
   assign bus.dout_i    = dout_i_q;
   assign bus.dout_q    = dout_q_q;
   assign bus.busy      = (frm_cnt_q != '0) || pend;

   if (DIST < NUM) begin : g_inbeat
      // Lower lane of butterfly pair p
      function automatic int unsigned lo_lane(input int unsigned p);
         return (p / DIST) * (2 * DIST) + (p % DIST);
      endfunction

      assign pend = 1'b0;

      // In-beat butterflies: lane j gets the sum, lane j+DIST the difference
      always_comb begin
         valid_d  = bus.valid_in;
         sop_d    = bus.valid_in && (frm_cnt_q == '0);
         dout_i_d = '0;
         dout_q_d = '0;
         if (bus.valid_in) begin
            for (int unsigned p = 0; p < NUM / 2; p++) begin
               dout_i_d[lo_lane(p)*OUT_WIDTH +: OUT_WIDTH] =
                  bf(bus.din_i[lo_lane(p)*IN_WIDTH +: IN_WIDTH],
                     bus.din_i[(lo_lane(p)+DIST)*IN_WIDTH +: IN_WIDTH], 1'b0);
               dout_i_d[(lo_lane(p)+DIST)*OUT_WIDTH +: OUT_WIDTH] =
                  bf(bus.din_i[lo_lane(p)*IN_WIDTH +: IN_WIDTH],
                     bus.din_i[(lo_lane(p)+DIST)*IN_WIDTH +: IN_WIDTH], 1'b1);
               dout_q_d[lo_lane(p)*OUT_WIDTH +: OUT_WIDTH] =
                  bf(bus.din_q[lo_lane(p)*IN_WIDTH +: IN_WIDTH],
                     bus.din_q[(lo_lane(p)+DIST)*IN_WIDTH +: IN_WIDTH], 1'b0);
               dout_q_d[(lo_lane(p)+DIST)*OUT_WIDTH +: OUT_WIDTH] =
                  bf(bus.din_q[lo_lane(p)*IN_WIDTH +: IN_WIDTH],
                     bus.din_q[(lo_lane(p)+DIST)*IN_WIDTH +: IN_WIDTH], 1'b1);
            end
         end
      end
   end else begin : g_buffered
      localparam int DEPTH = DIST / NUM;
      localparam int KW    = $clog2(2 * DEPTH);
      localparam int DW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int CW    = $clog2(DEPTH + 1);
      localparam int IL    = IN_WIDTH * NUM;

      logic [2*IL-1:0] half_mem [DEPTH];
      logic [2*LW-1:0] diff_mem [DEPTH];
      logic [KW-1:0]   k_d, k_q;
      logic [CW-1:0]   drain_cnt_d, drain_cnt_q;
      logic [DW-1:0]   wr_slot, rd_slot;
      logic [2*IL-1:0] a_word;
      logic [2*LW-1:0] d_word;
      logic [LW-1:0]   dif_i, dif_q;
      logic            fill, pair, drain;

      assign pend = (drain_cnt_q != '0);

      // Group sequencing, butterflies against the stored half, output select.
      // Draining is only armed once a group's last PAIR beat is in, so a
      // group's sums always precede its differences even with input gaps.
      always_comb begin
         fill    = bus.valid_in && !k_q[KW-1];
         pair    = bus.valid_in &&  k_q[KW-1];
         drain   = !pair && (drain_cnt_q != '0);
         wr_slot = (DEPTH > 1) ? DW'(k_q) : '0;
         rd_slot = DW'(CW'(DEPTH) - drain_cnt_q);
         a_word  = half_mem[wr_slot];
         d_word  = diff_mem[rd_slot];
         k_d     = bus.valid_in ? k_q + KW'(1) : k_q;

         drain_cnt_d = drain_cnt_q;
         if (pair && (k_q == '1))
            drain_cnt_d = CW'(DEPTH);
         else if (drain)
            drain_cnt_d = drain_cnt_q - CW'(1);

         dif_i    = '0;
         dif_q    = '0;
         dout_i_d = '0;
         dout_q_d = '0;
         for (int unsigned j = 0; j < NUM; j++) begin
            dif_i[j*OUT_WIDTH +: OUT_WIDTH] = bf(a_word[j*IN_WIDTH +: IN_WIDTH],
               bus.din_i[j*IN_WIDTH +: IN_WIDTH], 1'b1);
            dif_q[j*OUT_WIDTH +: OUT_WIDTH] = bf(a_word[IL + j*IN_WIDTH +: IN_WIDTH],
               bus.din_q[j*IN_WIDTH +: IN_WIDTH], 1'b1);
            if (pair) begin
               dout_i_d[j*OUT_WIDTH +: OUT_WIDTH] = bf(a_word[j*IN_WIDTH +: IN_WIDTH],
                  bus.din_i[j*IN_WIDTH +: IN_WIDTH], 1'b0);
               dout_q_d[j*OUT_WIDTH +: OUT_WIDTH] = bf(a_word[IL + j*IN_WIDTH +: IN_WIDTH],
                  bus.din_q[j*IN_WIDTH +: IN_WIDTH], 1'b0);
            end
         end
         if (drain) begin
            dout_i_d = d_word[LW-1:0];
            dout_q_d = d_word[2*LW-1:LW];
         end

         valid_d = pair || drain;
         sop_d   = pair && (frm_cnt_q == FW'(DEPTH));
      end

      // Group beat and drain counters
      always_ff @(posedge clk) begin
         if (rst) begin
            k_q         <= '0;
            drain_cnt_q <= '0;
         end else begin
            k_q         <= k_d;
            drain_cnt_q <= drain_cnt_d;
         end
      end

      // First-half buffer and difference queue writes
      always_ff @(posedge clk) begin
         if (fill) half_mem[wr_slot] <= {bus.din_q, bus.din_i};
         if (pair) diff_mem[wr_slot] <= {dif_q, dif_i};
      end
   end
endmodule

// File: tb/tb_fft_bfly_stage.sv
// tb_fft_bfly_stage: directed-vector bench for fft_bfly_stage (default
// DIST=256 instance plus a DIST=8 in-beat instance).
// Macro FFT_BFLY_SCALE_EN switches expected values to the halved results.
`timescale 1ns/1ps
module tb_fft_bfly_stage;
   localparam int IW   = 9;
   localparam int NUM  = 16;
   localparam int NUM1 = 32;
`ifdef FFT_BFLY_SCALE_EN
   localparam int OW = IW;
`else
   localparam int OW = IW + 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   fft_bfly_stage_if #(.IN_WIDTH(IW), .NUM(NUM))  bus0 ();
   fft_bfly_stage_if #(.IN_WIDTH(IW), .NUM(NUM1)) bus1 ();

   fft_bfly_stage #(.IN_WIDTH(IW), .NUM(NUM), .N(512), .DIST(256))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   fft_bfly_stage #(.IN_WIDTH(IW), .NUM(NUM1), .N(512), .DIST(8))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   logic [IW*NUM-1:0] st_i [128];
   logic [IW*NUM-1:0] st_q [128];
   logic [OW*NUM-1:0] ex_i [128];
   logic [OW*NUM-1:0] ex_q [128];
   logic [OW*NUM-1:0] cap_i [128];
   logic [OW*NUM-1:0] cap_q [128];
   logic              cap_sop [128];
   int                cap_cyc [128];
   int                n_cap;
   int                busy_last;

   // Expected value of one result given the exact sum/difference
   function automatic int res(input int x);
`ifdef FFT_BFLY_SCALE_EN
      return (x + 1) >>> 1;
`else
      return x;
`endif
   endfunction

   task automatic clear_vectors();
      for (int b = 0; b < 128; b++) begin
         st_i[b] = '0; st_q[b] = '0; ex_i[b] = '0; ex_q[b] = '0;
         cap_i[b] = 'x; cap_q[b] = 'x; cap_sop[b] = 1'bx; cap_cyc[b] = -1;
      end
   endtask

   // Drive nbeats from st_* (every cycle, or every other cycle with gap)
   // for ncyc cycles, recording each output beat and when busy was last high
   task automatic run_stream(input int nbeats, input bit gap, input int ncyc);
      int b = 0;
      n_cap = 0;
      busy_last = -1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (bus0.valid_out === 1'b1 && n_cap < 128) begin
            cap_i[n_cap]   = bus0.dout_i;
            cap_q[n_cap]   = bus0.dout_q;
            cap_sop[n_cap] = bus0.sop_out;
            cap_cyc[n_cap] = c;
            n_cap++;
         end
         if (bus0.busy === 1'b1) busy_last = c;
         if (b < nbeats && (!gap || (c % 2 == 0))) begin
            bus0.valid_in = 1'b1;
            bus0.din_i = st_i[b];
            bus0.din_q = st_q[b];
            b++;
         end else begin
            bus0.valid_in = 1'b0;
            bus0.din_i = '0;
            bus0.din_q = '0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus0.valid_in = 1'b0; bus0.din_i = '0; bus0.din_q = '0;
      bus1.valid_in = 1'b0; bus1.din_i = '0; bus1.din_q = '0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({bus0.valid_out, bus0.sop_out, bus0.busy} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 000", {bus0.valid_out, bus0.sop_out, bus0.busy});
      end
      n_vec++;
      if ({bus0.dout_i, bus0.dout_q} !== '0) begin
         n_err++;
         $display("FAIL reset_dout: got %h expected 0", {bus0.dout_i, bus0.dout_q});
      end
      n_vec++;
      if ({bus1.valid_out, bus1.busy} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_flags_d8: got %b expected 00", {bus1.valid_out, bus1.busy});
      end
      rst = 1'b0;
   endtask

   task automatic test_impulse(input string tag);
      clear_vectors();
      st_i[0][0 +: IW] = IW'(64);
      ex_i[0][0 +: OW] = OW'(res(64));
      ex_i[16][0 +: OW] = OW'(res(64));
      run_stream(32, 1'b0, 60);
      n_vec++;
      if (n_cap !== 32) begin
         n_err++;
         $display("FAIL %s_count: got %0d expected 32", tag, n_cap);
      end
      for (int b = 0; b < 32; b++) begin
         n_vec++;
         if (cap_cyc[b] !== 17 + b) begin
            n_err++;
            $display("FAIL %s_cycle[%0d]: got %0d expected %0d", tag, b, cap_cyc[b], 17 + b);
         end
         n_vec++;
         if (cap_sop[b] !== (b == 0)) begin
            n_err++;
            $display("FAIL %s_sop[%0d]: got %b expected %b", tag, b, cap_sop[b], b == 0);
         end
         n_vec++;
         if (cap_i[b] !== ex_i[b] || cap_q[b] !== ex_q[b]) begin
            n_err++;
            $display("FAIL %s_data[%0d]: got %h/%h expected %h/%h", tag, b, cap_i[b], cap_q[b], ex_i[b], ex_q[b]);
         end
      end
   endtask

   task automatic test_extremes();
      clear_vectors();
      st_i[0][3*IW +: IW]  = IW'(255);
      st_i[16][3*IW +: IW] = IW'(255);
      st_q[1][5*IW +: IW]  = IW'(-256);
      st_q[17][5*IW +: IW] = IW'(255);
      ex_i[0][3*OW +: OW]  = OW'(res(510));
      ex_i[16][3*OW +: OW] = OW'(res(0));
      ex_q[1][5*OW +: OW]  = OW'(res(-1));
      ex_q[17][5*OW +: OW] = OW'(res(-511));
      run_stream(32, 1'b0, 60);
      n_vec++;
      if (n_cap !== 32) begin
         n_err++;
         $display("FAIL extremes_count: got %0d expected 32", n_cap);
      end
      for (int b = 0; b < 32; b++) begin
         n_vec++;
         if (cap_i[b] !== ex_i[b] || cap_q[b] !== ex_q[b]) begin
            n_err++;
            $display("FAIL extremes_data[%0d]: got %h/%h expected %h/%h", b, cap_i[b], cap_q[b], ex_i[b], ex_q[b]);
         end
      end
   endtask

   task automatic test_gaps();
      int exp_cyc;
      clear_vectors();
      st_i[0][0 +: IW] = IW'(64);
      ex_i[0][0 +: OW] = OW'(res(64));
      ex_i[16][0 +: OW] = OW'(res(64));
      run_stream(32, 1'b1, 100);
      n_vec++;
      if (n_cap !== 32) begin
         n_err++;
         $display("FAIL gaps_count: got %0d expected 32", n_cap);
      end
      for (int b = 0; b < 32; b++) begin
         exp_cyc = (b < 16) ? 33 + 2 * b : 64 + (b - 16);
         n_vec++;
         if (cap_cyc[b] !== exp_cyc) begin
            n_err++;
            $display("FAIL gaps_cycle[%0d]: got %0d expected %0d", b, cap_cyc[b], exp_cyc);
         end
         n_vec++;
         if (cap_i[b] !== ex_i[b] || cap_q[b] !== ex_q[b] || cap_sop[b] !== (b == 0)) begin
            n_err++;
            $display("FAIL gaps_beat[%0d]: got %h/%h sop %b expected %h/%h sop %b", b, cap_i[b], cap_q[b], cap_sop[b], ex_i[b], ex_q[b], b == 0);
         end
      end
      n_vec++;
      if (busy_last < 78 || busy_last > 79) begin
         n_err++;
         $display("FAIL gaps_busy_last: got %0d expected 78..79", busy_last);
      end
      n_vec++;
      if (bus0.busy !== 1'b0) begin
         n_err++;
         $display("FAIL gaps_busy_idle: got %b expected 0", bus0.busy);
      end
   endtask

   task automatic test_back_to_back();
      clear_vectors();
      st_i[0][0 +: IW]   = IW'(64);
      st_i[32][1*IW +: IW] = IW'(-20);
      st_q[40][2*IW +: IW] = IW'(7);
      ex_i[0][0 +: OW]   = OW'(res(64));
      ex_i[16][0 +: OW]  = OW'(res(64));
      ex_i[32][1*OW +: OW] = OW'(res(-20));
      ex_i[48][1*OW +: OW] = OW'(res(-20));
      ex_q[40][2*OW +: OW] = OW'(res(7));
      ex_q[56][2*OW +: OW] = OW'(res(7));
      run_stream(64, 1'b0, 100);
      n_vec++;
      if (n_cap !== 64) begin
         n_err++;
         $display("FAIL b2b_count: got %0d expected 64", n_cap);
      end
      for (int b = 0; b < 64; b++) begin
         n_vec++;
         if (cap_cyc[b] !== 17 + b || cap_sop[b] !== (b == 0 || b == 32)) begin
            n_err++;
            $display("FAIL b2b_timing[%0d]: got cyc %0d sop %b expected cyc %0d sop %b", b, cap_cyc[b], cap_sop[b], 17 + b, (b == 0 || b == 32));
         end
         n_vec++;
         if (cap_i[b] !== ex_i[b] || cap_q[b] !== ex_q[b]) begin
            n_err++;
            $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", b, cap_i[b], cap_q[b], ex_i[b], ex_q[b]);
         end
      end
   endtask

   task automatic test_mid_reset();
      clear_vectors();
      st_i[0][0 +: IW] = IW'(64);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus0.valid_in = 1'b1;
         bus0.din_i = st_i[c];
         bus0.din_q = st_q[c];
      end
      @(negedge clk);
      n_vec++;
      if (bus0.busy !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_busy_before: got %b expected 1", bus0.busy);
      end
      bus0.valid_in = 1'b0;
      bus0.din_i = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if ({bus0.valid_out, bus0.busy} !== 2'b00) begin
         n_err++;
         $display("FAIL midrst_after: got %b expected 00", {bus0.valid_out, bus0.busy});
      end
      test_impulse("after_reset");
   endtask

   task automatic test_dist8();
      logic [OW*NUM1-1:0] exp_w;
      exp_w = '0;
      for (int l = 0; l < NUM1; l++)
         if ((l / 8) % 2 == 0) exp_w[l*OW +: OW] = OW'(res(200));
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_vec++;
         if (bus1.valid_out !== (c >= 1 && c <= 3)) begin
            n_err++;
            $display("FAIL d8_valid[%0d]: got %b expected %b", c, bus1.valid_out, (c >= 1 && c <= 3));
         end
         if (c >= 1 && c <= 3) begin
            n_vec++;
            if (bus1.dout_i !== exp_w || bus1.dout_q !== '0) begin
               n_err++;
               $display("FAIL d8_data[%0d]: got %h/%h expected %h/0", c, bus1.dout_i, bus1.dout_q, exp_w);
            end
            n_vec++;
            if (bus1.sop_out !== (c == 1)) begin
               n_err++;
               $display("FAIL d8_sop[%0d]: got %b expected %b", c, bus1.sop_out, c == 1);
            end
         end
         bus1.valid_in = (c < 3);
         for (int l = 0; l < NUM1; l++) bus1.din_i[l*IW +: IW] = (c < 3) ? IW'(100) : '0;
         bus1.din_q = '0;
      end
   endtask

   initial begin
      test_reset();
      test_impulse("impulse");
      test_extremes();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      test_dist8();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
